// File: rtl/spike_aer_packetizer.sv
// spike_aer_packetizer
// Turns neuron fire events into AER packets. Fired neuron indices are queued
// in a small FIFO. For each event the FSM issues one read on config port B,
// captures the returned SpikeAER word one cycle later, and presents it to the
// router.
//
// Handshake rule used on both sides of this block: a transfer happens on a
// rising clk_i edge where valid and ready are both high. A producer that has
// raised valid keeps valid and its data unchanged until that transfer edge.
// A consumer may raise or lower ready freely.
//   spike side : spikeVld_i / spikeRdy_o  (this block is the consumer)
//   router side: aerVld_o   / aerRdy_i    (this block is the producer)
module spike_aer_packetizer #(
    parameter int unsigned NURN_CNT_BIT_WIDTH = 8,
    parameter int unsigned AER_BIT_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH         = 4,
    parameter int unsigned FIFO_PTR_WIDTH     = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          spikeVld_i,
    input  logic [NURN_CNT_BIT_WIDTH-1:0] spikeNurnId_i,
    output logic                          spikeRdy_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0] Addr_Config_B_o,
    output logic                          rdEn_Config_B_o,
    input  logic [AER_BIT_WIDTH-1:0]      SpikeAER_i,
    output logic                          aerVld_o,
    output logic [AER_BIT_WIDTH-1:0]      aerData_o,
    input  logic                          aerRdy_i,
    output logic [FIFO_PTR_WIDTH:0]       pending_o,
    output logic                          busy_o
);

    // Occupancy value that means "full", sized to the occupancy counter.
    localparam logic [FIFO_PTR_WIDTH:0] FULL_CNT = (FIFO_PTR_WIDTH+1)'(FIFO_DEPTH);

    // IDLE: waiting for an event; READ: port-B read in flight;
    // CAPT: port-B data valid this cycle; SEND: packet offered to router.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAPT = 2'd2,
        ST_SEND = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [NURN_CNT_BIT_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [FIFO_PTR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FIFO_PTR_WIDTH:0]       count_q, count_d;

    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          push;
    logic                          pop;
    logic [NURN_CNT_BIT_WIDTH-1:0] head;

    // ------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------
    state_e                        state_q;
    logic [NURN_CNT_BIT_WIDTH-1:0] addr_q;
    logic                          rd_en_q;
    logic                          aer_vld_q;
    logic [AER_BIT_WIDTH-1:0]      aer_data_q;
    logic                          send_done;

    // Full is judged on the registered occupancy only, so a pop on the same
    // edge does not open the input while the FIFO reads full.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign spikeRdy_o = ~fifo_full;
    assign push       = spikeVld_i & ~fifo_full;
    assign head       = fifo_q[rd_ptr_q];

    // The router has taken the current packet at this edge.
    assign send_done  = (state_q == ST_SEND) & aer_vld_q & aerRdy_i;

    // The FSM pops only from IDLE or at a SEND handshake. Occupancy is the
    // pre-edge value, so an event pushed into an empty FIFO is never popped
    // on its own push edge.
    assign pop = ~fifo_empty & ((state_q == ST_IDLE) | send_done);

    // Next pointer and occupancy values from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage. Unreset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= spikeNurnId_i;
        end
    end

    // Pointer and occupancy registers. Reset discards all queued events.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Read/capture/send sequencer. All port-B and router outputs are
    // registered here.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            aer_vld_q  <= 1'b0;
            aer_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        addr_q  <= head;
                        rd_en_q <= 1'b1;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Read enable is a single-cycle pulse. The address
                    // stays put until the next read is issued.
                    rd_en_q <= 1'b0;
                    state_q <= ST_CAPT;
                end
                ST_CAPT: begin
                    aer_data_q <= SpikeAER_i;
                    aer_vld_q  <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    // Packet held stable until the router takes it. Data is
                    // left in place after the transfer.
                    if (send_done) begin
                        aer_vld_q <= 1'b0;
                        if (!fifo_empty) begin
                            // Chain straight into the next read to reach
                            // one packet every three cycles.
                            addr_q  <= head;
                            rd_en_q <= 1'b1;
                            state_q <= ST_READ;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Addr_Config_B_o = addr_q;
    assign rdEn_Config_B_o = rd_en_q;
    assign aerVld_o        = aer_vld_q;
    assign aerData_o       = aer_data_q;
    assign pending_o       = count_q;
    assign busy_o          = (state_q != ST_IDLE) | ~fifo_empty;

    // Structural invariants of the queue and sequencer.
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        pop |-> !fifo_empty);
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        count_q <= FULL_CNT);
    a_rden_pulse: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        rd_en_q |-> (state_q == ST_READ));
    a_vld_in_send: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        aer_vld_q |-> (state_q == ST_SEND));

endmodule

// File: tb/tb_spike_aer_packetizer.sv
// Bench for spike_aer_packetizer: a config port-B memory model with
// 1-cycle read latency, directed event sequences, and a scoreboard whose
// monitor checks every router transfer against the expected queue.
module tb_spike_aer_packetizer;

    logic        clk;
    logic        rst_n;
    logic        spike_vld;
    logic [7:0]  spike_id;
    logic        spike_rdy;
    logic [7:0]  cfg_addr;
    logic        cfg_rd_en;
    logic [31:0] spike_aer;
    logic        aer_vld;
    logic [31:0] aer_data;
    logic        aer_rdy;
    logic [2:0]  pending;
    logic        busy;

    logic [31:0] cfg_mem [256];
    logic [31:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs = -1;
    bit chk_rate = 1'b0;
    bit rnd_en = 1'b0;

    spike_aer_packetizer #(
        .NURN_CNT_BIT_WIDTH(8),
        .AER_BIT_WIDTH(32),
        .FIFO_DEPTH(4),
        .FIFO_PTR_WIDTH(2)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .spikeVld_i     (spike_vld),
        .spikeNurnId_i  (spike_id),
        .spikeRdy_o     (spike_rdy),
        .Addr_Config_B_o(cfg_addr),
        .rdEn_Config_B_o(cfg_rd_en),
        .SpikeAER_i     (spike_aer),
        .aerVld_o       (aer_vld),
        .aerData_o      (aer_data),
        .aerRdy_i       (aer_rdy),
        .pending_o      (pending),
        .busy_o         (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Config memory contents; entry 5 is 32'h0001_0005.
    function automatic logic [31:0] cfg_word(input logic [7:0] i);
        return {i ^ 8'h05, 8'h01, 8'h00, i};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) cfg_mem[i] = cfg_word(8'(i));
    end

    // Port-B memory model: registered read, data valid the cycle after rdEn.
    always @(posedge clk) begin
        if (cfg_rd_en) spike_aer <= cfg_mem[cfg_addr];
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: a transfer completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && aer_vld && aer_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_packet", aer_data, 32'hxxxx_xxxx);
            end else begin
                check("packet_data", aer_data, exp_q.pop_front());
            end
            if (chk_rate) begin
                if (last_hs >= 0) check("packet_spacing", 32'(cyc - last_hs), 32'd3);
                last_hs = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Offer one event; returns 1 time unit after the accepting edge.
    task automatic push_ev(input logic [7:0] id);
        int n;
        spike_vld = 1'b1;
        spike_id  = id;
        n = 0;
        while (!spike_rdy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("push_ready", {31'd0, spike_rdy}, 32'd1);
        @(posedge clk);
        exp_q.push_back(cfg_mem[id]);
        #1;
        spike_vld = 1'b0;
    endtask

    task automatic wait_vld();
        int n;
        n = 0;
        while (!aer_vld && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_vld", {31'd0, aer_vld}, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", {31'd0, busy | (exp_q.size() != 0)}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_spikeRdy"}, {31'd0, spike_rdy}, 32'd1);
        check({tag, "_rdEn"},     {31'd0, cfg_rd_en}, 32'd0);
        check({tag, "_addr"},     {24'd0, cfg_addr},  32'd0);
        check({tag, "_aerVld"},   {31'd0, aer_vld},   32'd0);
        check({tag, "_aerData"},  aer_data,           32'd0);
        check({tag, "_pending"},  {29'd0, pending},   32'd0);
        check({tag, "_busy"},     {31'd0, busy},      32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        spike_vld = 1'b0;
        spike_id  = 8'd0;
        aer_rdy   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_in");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("rst_out");

        // Single event with latency checks.
        aer_rdy = 1'b1;
        push_ev(8'd5);
        check("single_pend_e0", {29'd0, pending}, 32'd1);
        check("single_rden_e0", {31'd0, cfg_rd_en}, 32'd0);
        @(posedge clk); #1;
        check("single_rden_e1", {31'd0, cfg_rd_en}, 32'd1);
        check("single_addr_e1", {24'd0, cfg_addr}, 32'd5);
        check("single_pend_e1", {29'd0, pending}, 32'd0);
        @(posedge clk); #1;
        check("single_rden_e2", {31'd0, cfg_rd_en}, 32'd0);
        check("single_addr_e2", {24'd0, cfg_addr}, 32'd5);
        check("single_vld_e2",  {31'd0, aer_vld}, 32'd0);
        @(posedge clk); #1;
        check("single_vld_e3",  {31'd0, aer_vld}, 32'd1);
        check("single_data_e3", aer_data, 32'h0001_0005);
        @(posedge clk); #1;
        check("single_vld_e4",  {31'd0, aer_vld}, 32'd0);
        check("single_busy_e4", {31'd0, busy}, 32'd0);
        check("single_hold_e4", aer_data, 32'h0001_0005);

        // Burst into a full FIFO, then drain at full rate.
        aer_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) push_ev(8'(i));
        check("burst_pend_full", {29'd0, pending}, 32'd4);
        check("burst_rdy_low",   {31'd0, spike_rdy}, 32'd0);
        check("burst_head_data", aer_data, cfg_word(8'd1));
        repeat (3) @(posedge clk);
        #1;
        check("burst_still_full", {29'd0, pending}, 32'd4);
        check("burst_still_low",  {31'd0, spike_rdy}, 32'd0);
        chk_rate = 1'b1;
        last_hs  = -1;
        aer_rdy  = 1'b1;
        @(posedge clk); #1;
        check("burst_pend_pop",  {29'd0, pending}, 32'd3);
        check("burst_rdy_back",  {31'd0, spike_rdy}, 32'd1);
        check("burst_next_rden", {31'd0, cfg_rd_en}, 32'd1);
        check("burst_next_addr", {24'd0, cfg_addr}, 32'd2);
        wait_drain();
        chk_rate = 1'b0;

        // Backpressure held for 10 cycles during SEND.
        aer_rdy = 1'b0;
        push_ev(8'd7);
        push_ev(8'd8);
        wait_vld();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {aer_vld, cfg_rd_en, 30'd0} ^ aer_data,
                  {1'b1, 1'b0, 30'd0} ^ cfg_word(8'd7));
            check("bp_pend", {29'd0, pending}, 32'd1);
        end
        aer_rdy = 1'b1;
        @(posedge clk); #1;
        aer_rdy = 1'b0;
        check("bp_rel_vld",  {31'd0, aer_vld}, 32'd0);
        check("bp_rel_rden", {31'd0, cfg_rd_en}, 32'd1);
        check("bp_rel_addr", {24'd0, cfg_addr}, 32'd8);
        check("bp_rel_pend", {29'd0, pending}, 32'd0);
        aer_rdy = 1'b1;
        wait_drain();

        // Push on the same edge as a SEND-handshake pop.
        aer_rdy = 1'b0;
        push_ev(8'd10);
        push_ev(8'd11);
        push_ev(8'd12);
        wait_vld();
        check("sim_pend_before", {29'd0, pending}, 32'd2);
        aer_rdy = 1'b1;
        push_ev(8'd9);
        check("sim_pend_after", {29'd0, pending}, 32'd2);
        check("sim_rden",       {31'd0, cfg_rd_en}, 32'd1);
        check("sim_addr",       {24'd0, cfg_addr}, 32'd11);
        wait_drain();

        // Stream of 12 events with random router readiness (pointer wrap).
        rnd_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 12; i++) push_ev(8'(i));
                wait_drain();
                rnd_en = 1'b0;
            end
            begin
                while (rnd_en) begin
                    @(posedge clk); #1;
                    aer_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        aer_rdy = 1'b1;
        check("wrap_pend", {29'd0, pending}, 32'd0);

        // Reset while a packet is offered and three events are queued.
        aer_rdy = 1'b0;
        for (int i = 20; i <= 23; i++) push_ev(8'(i));
        check("rst_mid_vld",  {31'd0, aer_vld}, 32'd1);
        check("rst_mid_pend", {29'd0, pending}, 32'd3);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n   = 1'b1;
        aer_rdy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_vld",  {31'd0, aer_vld}, 32'd0);
        check("post_rst_rden", {31'd0, cfg_rd_en}, 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
